// File: rtl/dnoc_itf_out_arb.sv
// ---------------------------------------------------------------------------
// dnoc_itf_out_arb
//
// Output arbiter of the DNoC interface. Several channels each present a
// prebuilt single-flit packet (head_flit) together with a request. One
// channel is picked round-robin. Its flit is latched and, if the channel
// asks for it, a multicast sync is run first. The flit is then sent on the
// NoC as a one-flit packet. When the NoC accepts it, the channel receives a
// one-cycle gnt pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NUM_CH]         per-channel send request
//   gnt[NUM_CH]         per-channel completion pulse (same cycle as the
//                       NoC handshake)
//   head_flit           NUM_CH x FLIT_W prebuilt head flits
//   sync_req[NUM_CH]    channel's packet needs a sync before sending
//   sync_tgt            NUM_CH x SYNC_W sync target sets
//   sync_init           one-cycle sync start pulse
//   sync_target         target presented with sync_init; 0 otherwise
//   sync_hit            sync completed
//   sync_to_cfg         sync timeout in cycles; 0 disables the timeout
//   sync_err            one-cycle timeout pulse (a retry starts with it)
//   in_flit/in_valid/in_last/in_ready   NoC injection port
//   busy                arbiter is not idle
// ---------------------------------------------------------------------------
module dnoc_itf_out_arb #(
   parameter int unsigned NODE_ID = 4'd0,
   parameter int          NUM_CH  = 2,
   parameter int          FLIT_W  = 256,
   parameter int          SYNC_W  = 12,
   parameter int          TO_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req,
   output logic [NUM_CH-1:0]        gnt,
   input  logic [NUM_CH*FLIT_W-1:0] head_flit,
   input  logic [NUM_CH-1:0]        sync_req,
   input  logic [NUM_CH*SYNC_W-1:0] sync_tgt,
   output logic                     sync_init,
   output logic [SYNC_W-1:0]        sync_target,
   input  logic                     sync_hit,
   input  logic [TO_W-1:0]          sync_to_cfg,
   output logic                     sync_err,
   output logic [FLIT_W-1:0]        in_flit,
   output logic                     in_valid,
   output logic                     in_last,
   input  logic                     in_ready,
   output logic                     busy
);

   localparam int IDX_W = $clog2(NUM_CH);

   // The local node never syncs with itself.
   localparam logic [SYNC_W-1:0] NODE_MASK = ~(SYNC_W'(1) << NODE_ID);
   localparam logic [IDX_W:0]    NUM_CH_W  = (IDX_W+1)'(NUM_CH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      SEND
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    idx_q;
   logic [FLIT_W-1:0]   flit_q;
   logic [SYNC_W-1:0]   tgt_q;
   logic [TO_W-1:0]     to_cnt;

   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [IDX_W:0]      cand;
   logic [FLIT_W-1:0]   sel_flit;
   logic [SYNC_W-1:0]   sel_tgt;
   logic                sync_timeout;

   // Timeout counter sticks at all-ones instead of wrapping.
   function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
      return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (v == LAST_IDX) ? '0 : v + 1'b1;
   endfunction

   // Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand >= NUM_CH_W) begin
            cand = cand - NUM_CH_W;
         end
         if (!sel_found && req[cand[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign sel_flit = head_flit[int'(sel_idx)*FLIT_W +: FLIT_W];
   assign sel_tgt  = sync_tgt[int'(sel_idx)*SYNC_W +: SYNC_W];

   // to_cnt counts hit-less cycles of the current attempt, so the last
   // cycle of an attempt is the one where it reaches sync_to_cfg-1.
   assign sync_timeout = (sync_to_cfg != '0) && (to_cnt == sync_to_cfg - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         idx_q       <= '0;
         flit_q      <= '0;
         tgt_q       <= '0;
         to_cnt      <= '0;
         sync_init   <= 1'b0;
         sync_target <= '0;
         sync_err    <= 1'b0;
      end else begin
         sync_init   <= 1'b0;
         sync_target <= '0;
         sync_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  idx_q  <= sel_idx;
                  flit_q <= sel_flit;
                  tgt_q  <= sel_tgt & NODE_MASK;
                  to_cnt <= '0;
                  if (sync_req[sel_idx]) begin
                     state       <= SYNC;
                     sync_init   <= 1'b1;
                     sync_target <= sel_tgt & NODE_MASK;
                  end else begin
                     state <= SEND;
                  end
               end
            end
            SYNC: begin
               // A hit in the timeout cycle still counts as success.
               if (sync_hit) begin
                  state  <= SEND;
                  to_cnt <= '0;
               end else if (sync_timeout) begin
                  sync_err    <= 1'b1;
                  sync_init   <= 1'b1;
                  sync_target <= tgt_q;
                  to_cnt      <= '0;
               end else begin
                  to_cnt <= sat_inc(to_cnt);
               end
            end
            SEND: begin
               if (in_ready) begin
                  rr_ptr <= wrap_inc(idx_q);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // gnt follows the handshake combinationally so it lands in the accept cycle.
   always_comb begin
      gnt = '0;
      if ((state == SEND) && in_ready) begin
         gnt[idx_q] = 1'b1;
      end
   end

   assign in_valid = (state == SEND);
   assign in_last  = (state == SEND);
   assign in_flit  = (state == SEND) ? flit_q : '0;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dnoc_itf_out_arb.sv
module tb_dnoc_itf_out_arb;
   localparam int NUM_CH  = 4;
   localparam int FLIT_W  = 64;
   localparam int SYNC_W  = 12;
   localparam int TO_W    = 16;
   localparam int NODE_ID = 3;
   // Target mask for node 3: bit 3 cleared.
   localparam logic [SYNC_W-1:0] TB_MASK = 12'hFF7;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        gnt;
   logic [NUM_CH*FLIT_W-1:0] head_flit;
   logic [NUM_CH-1:0]        sync_req;
   logic [NUM_CH*SYNC_W-1:0] sync_tgt;
   logic                     sync_init;
   logic [SYNC_W-1:0]        sync_target;
   logic                     sync_hit;
   logic [TO_W-1:0]          sync_to_cfg;
   logic                     sync_err;
   logic [FLIT_W-1:0]        in_flit;
   logic                     in_valid;
   logic                     in_last;
   logic                     in_ready;
   logic                     busy;

   dnoc_itf_out_arb #(
      .NODE_ID (NODE_ID),
      .NUM_CH  (NUM_CH),
      .FLIT_W  (FLIT_W),
      .SYNC_W  (SYNC_W),
      .TO_W    (TO_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .head_flit   (head_flit),
      .sync_req    (sync_req),
      .sync_tgt    (sync_tgt),
      .sync_init   (sync_init),
      .sync_target (sync_target),
      .sync_hit    (sync_hit),
      .sync_to_cfg (sync_to_cfg),
      .sync_err    (sync_err),
      .in_flit     (in_flit),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: packet-level view (idle / syncing / sending).
   int                m_mode = 0;   // 0 idle, 1 syncing, 2 sending
   int                m_ch   = 0;
   int                m_next = 0;   // first channel to look at next time
   int                m_wait = 0;   // hit-less cycles in current sync attempt
   logic [FLIT_W-1:0] m_flit = '0;
   logic [SYNC_W-1:0] m_tgt  = '0;
   bit                m_init = 0;
   bit                m_err  = 0;
   bit                m_pick;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0; m_ch = 0; m_next = 0; m_wait = 0;
         m_flit = '0; m_tgt = '0; m_init = 0; m_err = 0;
      end else begin
         m_init = 0;
         m_err  = 0;
         if (m_mode == 0) begin
            m_pick = 0;
            for (int k = 0; k < NUM_CH; k++) begin
               int c;
               c = (m_next + k) % NUM_CH;
               if (!m_pick && req[c]) begin
                  m_pick = 1;
                  m_ch   = c;
                  m_flit = head_flit[c*FLIT_W +: FLIT_W];
                  m_tgt  = sync_tgt[c*SYNC_W +: SYNC_W] & TB_MASK;
                  if (sync_req[c]) begin
                     m_mode = 1; m_wait = 0; m_init = 1;
                  end else begin
                     m_mode = 2;
                  end
               end
            end
         end else if (m_mode == 1) begin
            if (sync_hit) begin
               m_mode = 2;
            end else if (sync_to_cfg != 0 && m_wait == int'(sync_to_cfg) - 1) begin
               m_err = 1; m_init = 1; m_wait = 0;
            end else begin
               m_wait++;
            end
         end else if (in_ready) begin
            m_next = (m_ch + 1) % NUM_CH;
            m_mode = 0;
         end
      end
   end

   logic [NUM_CH-1:0] e_gnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         check_eq("m_gnt", gnt, 0);
         check_eq("m_in_valid", in_valid, 0);
         check_eq("m_in_last", in_last, 0);
         check_eq("m_in_flit", in_flit, 0);
         check_eq("m_sync_init", sync_init, 0);
         check_eq("m_sync_target", sync_target, 0);
         check_eq("m_sync_err", sync_err, 0);
         check_eq("m_busy", busy, 0);
      end else begin
         e_gnt = (m_mode == 2 && in_ready) ? (4'b0001 << m_ch) : 4'b0000;
         check_eq("m_gnt", gnt, e_gnt);
         check_eq("m_in_valid", in_valid, m_mode == 2);
         check_eq("m_in_last", in_last, m_mode == 2);
         check_eq("m_in_flit", in_flit, (m_mode == 2) ? m_flit : '0);
         check_eq("m_sync_init", sync_init, m_init);
         check_eq("m_sync_target", sync_target, m_init ? m_tgt : '0);
         check_eq("m_sync_err", sync_err, m_err);
         check_eq("m_busy", busy, m_mode != 0);
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NUM_CH-1:0] g_seen [3];
      logic [FLIT_W-1:0] f_seen [3];
      int                c_seen [3];
      int                n;
      bit                found;
      int                err_off;
      bit                init_at_err;
      logic [SYNC_W-1:0] tgt_at_err;

      rst_n = 1'b0; req = '0; head_flit = '0; sync_req = '0; sync_tgt = '0;
      sync_hit = 1'b0; sync_to_cfg = '0; in_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_valid", in_valid, 0);
      check_eq("rst_sync_init", sync_init, 0);
      step();
      rst_n = 1'b1;
      step();

      // Two requesters, no sync: ch0, ch1, ch0 with a bubble between packets
      head_flit[0*FLIT_W +: FLIT_W] = 64'hA0A0_0000_1111_0000;
      head_flit[1*FLIT_W +: FLIT_W] = 64'hB1B1_0000_2222_0001;
      req = 4'b0011; in_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
         @(negedge clk);
         if (gnt != 0) begin
            g_seen[n] = gnt; f_seen[n] = in_flit; c_seen[n] = cyc; n++;
         end
      end
      check_eq("a_count", n, 3);
      check_eq("a_gnt0", g_seen[0], 4'b0001);
      check_eq("a_gnt1", g_seen[1], 4'b0010);
      check_eq("a_gnt2", g_seen[2], 4'b0001);
      check_eq("a_flit0", f_seen[0], 64'hA0A0_0000_1111_0000);
      check_eq("a_flit1", f_seen[1], 64'hB1B1_0000_2222_0001);
      check_eq("a_flit2", f_seen[2], 64'hA0A0_0000_1111_0000);
      check_eq("a_lat0", c_seen[0], 1);
      check_eq("a_lat1", c_seen[1], 3);
      check_eq("a_lat2", c_seen[2], 5);
      step();
      req = '0;
      step();

      // Sync on ch1 with own node masked out of the target
      head_flit[1*FLIT_W +: FLIT_W] = 64'hC0C0_3333_4444_5555;
      sync_tgt[1*SYNC_W +: SYNC_W] = 12'h00F;
      sync_req = 4'b0010; req = 4'b0010;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (sync_init === 1'b1) found = 1;
      end
      check_eq("b_init_seen", found, 1);
      check_eq("b_target", sync_target, 12'h007);
      step();
      req = '0;
      repeat (3) step();
      sync_hit = 1'b1;
      @(negedge clk);
      check_eq("b_valid_before", in_valid, 0);
      check_eq("b_busy", busy, 1);
      step();
      sync_hit = 1'b0;
      @(negedge clk);
      check_eq("b_valid_after", in_valid, 1);
      check_eq("b_flit", in_flit, 64'hC0C0_3333_4444_5555);
      check_eq("b_gnt", gnt, 4'b0010);
      step();
      sync_req = '0;

      // Back-pressure: flit held stable, gnt only on the accept cycle
      head_flit[2*FLIT_W +: FLIT_W] = 64'hD2D2_6666_7777_8888;
      req = 4'b0100; in_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 0) begin
            req = '0;
            head_flit[2*FLIT_W +: FLIT_W] = 64'h1234_5678_9ABC_DEF0;
         end
         @(negedge clk);
         check_eq("c_valid", in_valid, 1);
         check_eq("c_flit", in_flit, 64'hD2D2_6666_7777_8888);
         check_eq("c_gnt_held", gnt, 0);
      end
      step();
      in_ready = 1'b1;
      @(negedge clk);
      check_eq("c_gnt", gnt, 4'b0100);
      step();

      // Timeout retry after 8 cycles, then hit in the timeout cycle
      sync_to_cfg = 16'd8;
      head_flit[0*FLIT_W +: FLIT_W] = 64'hE0E0_9999_AAAA_BBBB;
      sync_tgt[0*SYNC_W +: SYNC_W] = 12'hABC;
      sync_req = 4'b0001; req = 4'b0001;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (sync_init === 1'b1) found = 1;
      end
      check_eq("d_init_seen", found, 1);
      check_eq("d_target", sync_target, 12'hAB4);
      err_off = -1; init_at_err = 0; tgt_at_err = '0;
      for (int off = 1; off <= 12 && err_off < 0; off++) begin
         step();
         if (off == 1) req = '0;
         @(negedge clk);
         if (sync_err === 1'b1) begin
            err_off = off; init_at_err = sync_init; tgt_at_err = sync_target;
         end
      end
      check_eq("d_err_offset", err_off, 8);
      check_eq("d_reinit", init_at_err, 1);
      check_eq("d_retarget", tgt_at_err, 12'hAB4);
      repeat (6) step();
      step();
      sync_hit = 1'b1;
      @(negedge clk);
      check_eq("d_hit_noerr", sync_err, 0);
      step();
      sync_hit = 1'b0;
      @(negedge clk);
      check_eq("d_after_noerr", sync_err, 0);
      check_eq("d_send", in_valid, 1);
      check_eq("d_flit", in_flit, 64'hE0E0_9999_AAAA_BBBB);
      check_eq("d_gnt", gnt, 4'b0001);
      step();
      sync_to_cfg = '0; sync_req = '0;

      // Reset during SEND aborts; pending request restarts from ch0
      head_flit[0*FLIT_W +: FLIT_W] = 64'hF0F0_0000_0000_00F0;
      head_flit[1*FLIT_W +: FLIT_W] = 64'hF1F1_0000_0000_00F1;
      req = 4'b0011; in_ready = 1'b0;
      step();
      @(negedge clk);
      check_eq("e_valid", in_valid, 1);
      check_eq("e_flit_ch1", in_flit, 64'hF1F1_0000_0000_00F1);
      step();
      rst_n = 1'b0; in_ready = 1'b1;
      #1;
      check_eq("e_valid_drop", in_valid, 0);
      check_eq("e_no_gnt", gnt, 0);
      check_eq("e_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("e_idle", busy, 0);
      step();
      @(negedge clk);
      check_eq("e_restart_gnt", gnt, 4'b0001);
      check_eq("e_restart_flit", in_flit, 64'hF0F0_0000_0000_00F0);
      step();
      req = '0;
      step();

      // Single requester ch3 granted every 2 cycles
      req = 4'b1000; in_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         check_eq("f_gnt", gnt, (cyc % 2 == 1) ? 4'b1000 : 4'b0000);
      end
      step();
      req = '0;
      step();

      // Randomized traffic against the reference model
      for (int n2 = 0; n2 < 500; n2++) begin
         step();
         req      = 4'($urandom_range(0, 15));
         sync_req = 4'($urandom & $urandom);
         for (int c = 0; c < NUM_CH; c++) begin
            head_flit[c*FLIT_W +: FLIT_W] = {$urandom, $urandom};
            sync_tgt[c*SYNC_W +: SYNC_W]  = 12'($urandom);
         end
         sync_hit = ($urandom_range(0, 4) == 0);
         in_ready = ($urandom_range(0, 3) != 0);
         if (n2 % 50 == 0) sync_to_cfg = 16'($urandom_range(0, 6));
         rst_n = (n2 != 250);
      end
      step();
      rst_n = 1'b1;
      req = '0;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
